int_ctrl: RTL and testbench
===========================

INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 irq_in  input  4  interrupt sources; bit 0 highest priority, bit 3 lowest.
REQ-004 mask_we  input  1  mask write strobe; when high, mask register loads mask_data that cycle.
REQ-005 mask_data  input  4  new mask value; 1 = source enabled, 0 = masked.
REQ-006 int_ack  input  1  control unit pulse: return address saved, jump to int_vector taken.
REQ-007 int_done  input  1  control unit pulse: handler finished (end of interrupt).
REQ-008 interrupt  output  1  interrupt request to the control unit.
REQ-009 int_vector  output  8  handler jump address for the granted source.
REQ-010 in_service  output  4  one-hot id of the source being serviced; 0 when none.
REQ-011 irq_count  output  8  count of acknowledged interrupts, saturating at 8'hFF.

Function
REQ-012 Each irq_in bit SHALL be registered once; a pending bit SHALL set on a 0->1 transition of the registered value (one-cycle edge detect).
REQ-013 Pending bits SHALL latch regardless of mask; a masked pending bit SHALL be held, not requested, and requested once unmasked.
REQ-014 The effective request SHALL be pending AND mask; the grant SHALL be the lowest-numbered set bit.
REQ-015 The FSM SHALL have three states: IDLE, REQ, SERVICE.
REQ-016 IDLE -> REQ when the effective request is nonzero; on that edge the grant id SHALL be latched and int_vector set to 8'hF8 + 2*id (F8, FA, FC, FE).
REQ-017 In REQ, interrupt SHALL be 1 and int_vector SHALL stay constant until int_ack, even if the granted source is masked or a higher-priority edge arrives.
REQ-018 REQ -> SERVICE on int_ack: the latched id's pending bit SHALL clear, in_service SHALL become the one-hot id, interrupt SHALL drop to 0 the next cycle, and irq_count SHALL increment unless at 8'hFF.
REQ-019 If a new edge on the latched source coincides with the clearing int_ack, the pending bit SHALL remain set (set wins).
REQ-020 No nesting: in SERVICE, interrupt SHALL stay 0; new edges SHALL only set pending bits.
REQ-021 SERVICE -> IDLE on int_done; in_service SHALL clear the same edge. If the effective request is nonzero, REQ SHALL be entered on the following cycle, giving one IDLE cycle minimum between services.
REQ-022 int_done in IDLE or REQ, and int_ack in IDLE or SERVICE, SHALL be ignored with no state change.
REQ-023 int_ack and int_done high together in REQ SHALL be treated as int_ack only.
REQ-024 Latency: an irq_in rise at edge N SHALL give interrupt = 1 after edge N+3 if enabled and the FSM is IDLE (register, pending, REQ).
REQ-025 A mask write SHALL take effect for arbitration in the cycle after mask_we.

Reset
REQ-026 Reset SHALL force: state IDLE, pending 0, mask 4'hF, irq_in register 0, interrupt 0, int_vector 8'h00, in_service 0, irq_count 0.
REQ-027 Reset SHALL take priority over all other inputs, including mid-REQ or mid-SERVICE; a service in progress SHALL be abandoned without int_done.
REQ-028 An irq_in bit held high through reset release SHALL generate one pending edge after release, because the input register resets to 0.

Verification
REQ-029 After reset, pulse irq_in[2] -> interrupt = 1 three edges later, int_vector = 8'hFC; int_ack -> in_service = 4'b0100, irq_count = 1.
REQ-030 irq_in[3] and irq_in[1] rise on the same edge -> vector 8'hFA first; after ack/done, one IDLE cycle, then vector 8'hFE.
REQ-031 mask_data = 4'b1110, then pulse irq_in[0] -> interrupt stays 0; write mask 4'hF -> interrupt = 1 the next cycle after mask takes effect, vector 8'hF8.
REQ-032 In REQ for source 1, pulse irq_in[0] -> vector stays 8'hFA until ack; after done, source 0 is serviced with vector 8'hF8.
REQ-033 Assert reset during SERVICE with irq_in[1] held high -> all outputs return to reset values; after release, interrupt rises with vector 8'hFA.
REQ-034 Run 260 ack/done cycles -> irq_count saturates at 8'hFF; a stray int_done in IDLE causes no output change.

Source files
------------

// File: rtl/int_ctrl.sv
// int_ctrl: four-source prioritized interrupt controller.
// Sources are registered, edge-detected into pending bits, masked, and the
// lowest-numbered active request is presented to the control unit as a
// handler vector. One interrupt is serviced at a time (no nesting).
module int_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] irq_in,
   input  logic       mask_we,
   input  logic [3:0] mask_data,
   input  logic       int_ack,
   input  logic       int_done,
   output logic       interrupt,
   output logic [7:0] int_vector,
   output logic [3:0] in_service,
   output logic [7:0] irq_count
);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t     state, state_nxt;
   logic [3:0] irq_r, irq_r2;
   logic [3:0] pending, mask;
   logic [3:0] irq_edge, eff_req, clr_mask;
   logic [1:0] gnt_id, id_q;
   logic       take_grant, do_ack, do_done;

   // Rising edge of the registered source; irq_r2 is only the edge-detect history.
   assign irq_edge = irq_r & ~irq_r2;
   assign eff_req  = pending & mask;
   // Clear only the latched source's pending bit, and only on acknowledge.
   assign clr_mask = do_ack ? (4'b0001 << id_q) : 4'b0000;

   // Fixed priority: lowest-numbered effective request wins.
   always_comb begin
      gnt_id = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (eff_req[i]) gnt_id = 2'(i);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; stray ack/done outside their state are ignored, and
   // ack wins over a simultaneous done in REQ.
   always_comb begin
      state_nxt  = state;
      take_grant = 1'b0;
      do_ack     = 1'b0;
      do_done    = 1'b0;
      interrupt  = 1'b0;
      case (state)
         IDLE: begin
            if (|eff_req) begin
               state_nxt  = REQ;
               take_grant = 1'b1;
            end
         end
         REQ: begin
            interrupt = 1'b1;
            if (int_ack) begin
               state_nxt = SERVICE;
               do_ack    = 1'b1;
            end
         end
         SERVICE: begin
            if (int_done) begin
               state_nxt = IDLE;
               do_done   = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: input sampling, pending/mask, latched grant, service id, counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_r      <= 4'h0;
         irq_r2     <= 4'h0;
         pending    <= 4'h0;
         mask       <= 4'hF;
         id_q       <= 2'd0;
         int_vector <= 8'h00;
         in_service <= 4'h0;
         irq_count  <= 8'h00;
      end else begin
         irq_r   <= irq_in;
         irq_r2  <= irq_r;
         // A new edge on the source being cleared keeps its bit set.
         pending <= (pending & ~clr_mask) | irq_edge;
         if (mask_we) mask <= mask_data;
         // Vector is frozen once latched so it stays stable through REQ.
         if (take_grant) begin
            id_q       <= gnt_id;
            int_vector <= 8'hF8 + {5'b00000, gnt_id, 1'b0};
         end
         if (do_ack) begin
            in_service <= 4'b0001 << id_q;
            if (irq_count != 8'hFF) irq_count <= irq_count + 8'd1;
         end
         if (do_done) in_service <= 4'h0;
      end
   end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: table of per-cycle vectors plus
// hand-written reset-in-service and counter-saturation sequences.
module tb_int_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] irq_in;
   logic       mask_we;
   logic [3:0] mask_data;
   logic       int_ack;
   logic       int_done;
   logic       interrupt;
   logic [7:0] int_vector;
   logic [3:0] in_service;
   logic [7:0] irq_count;

   typedef struct packed {
      logic       intr;
      logic [7:0] vec;
      logic [3:0] svc;
      logic [7:0] cnt;
   } exp_t;

   typedef struct packed {
      logic       rst;
      logic [3:0] irq;
      logic       mwe;
      logic [3:0] md;
      logic       ack;
      logic       done;
      exp_t       e;
   } vec_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   int_ctrl dut (
      .clk(clk), .reset(reset), .irq_in(irq_in), .mask_we(mask_we),
      .mask_data(mask_data), .int_ack(int_ack), .int_done(int_done),
      .interrupt(interrupt), .int_vector(int_vector),
      .in_service(in_service), .irq_count(irq_count)
   );

   always #5 clk = ~clk;

   task automatic add(input logic r, input logic [3:0] irq, input logic mwe,
                      input logic [3:0] md, input logic a, input logic d,
                      input logic i, input logic [7:0] v, input logic [3:0] s,
                      input logic [7:0] c);
      vec_t t;
      t.rst = r; t.irq = irq; t.mwe = mwe; t.md = md; t.ack = a; t.done = d;
      t.e.intr = i; t.e.vec = v; t.e.svc = s; t.e.cnt = c;
      tbl.push_back(t);
   endtask

   // Drive one cycle of inputs at negedge, queue the expectation, then check
   // the outputs just after the following rising edge.
   task automatic step(input vec_t t, input string tag, input int idx);
      exp_t want, got;
      @(negedge clk);
      reset = t.rst; irq_in = t.irq; mask_we = t.mwe; mask_data = t.md;
      int_ack = t.ack; int_done = t.done;
      sb.push_back(t.e);
      @(posedge clk);
      #1;
      want = sb.pop_front();
      got.intr = interrupt; got.vec = int_vector;
      got.svc = in_service; got.cnt = irq_count;
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s[%0d]: got int=%b vec=%h svc=%b cnt=%h, expected int=%b vec=%h svc=%b cnt=%h",
                  tag, idx, got.intr, got.vec, got.svc, got.cnt,
                  want.intr, want.vec, want.svc, want.cnt);
      end
   endtask

   task automatic drv(input logic r, input logic [3:0] irq, input logic a,
                      input logic d, input logic i, input logic [7:0] v,
                      input logic [3:0] s, input logic [7:0] c,
                      input string tag, input int idx);
      vec_t t;
      t.rst = r; t.irq = irq; t.mwe = 1'b0; t.md = 4'h0; t.ack = a; t.done = d;
      t.e.intr = i; t.e.vec = v; t.e.svc = s; t.e.cnt = c;
      step(t, tag, idx);
   endtask

   initial begin
      logic [7:0] cnt;
      reset = 1'b1; irq_in = 4'h0; mask_we = 1'b0; mask_data = 4'h0;
      int_ack = 1'b0; int_done = 1'b0;

      //   rst  irq   mwe  md    ack  done | int  vec    svc   cnt
      // reset, then single source 2: three edges to interrupt
      add(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'd0);
      add(1'b0, 4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'd0);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'd0);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'hFC, 4'h0, 8'd0);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 8'hFC, 4'h0, 8'd0); // done in REQ ignored
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'hFC, 4'h4, 8'd1);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'hFC, 4'h4, 8'd1); // ack in SERVICE ignored
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 8'hFC, 4'h0, 8'd1);
      // sources 3 and 1 together: 1 first, one IDLE cycle, then 3
      add(1'b0, 4'hA, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'hFC, 4'h0, 8'd1);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'hFC, 4'h0, 8'd1);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'hFA, 4'h0, 8'd1);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'hFA, 4'h2, 8'd2);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 8'hFA, 4'h0, 8'd2);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'hFE, 4'h0, 8'd2);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 8'hFE, 4'h8, 8'd3); // ack+done = ack
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 8'hFE, 4'h0, 8'd3);
      // masked source 0 is held, then requested once unmasked
      add(1'b0, 4'h0, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 8'hFE, 4'h0, 8'd3);
      add(1'b0, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'hFE, 4'h0, 8'd3);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'hFE, 4'h0, 8'd3);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'hFE, 4'h0, 8'd3);
      add(1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 8'hFE, 4'h0, 8'd3);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'hF8, 4'h0, 8'd3);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'hF8, 4'h1, 8'd4);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 8'hF8, 4'h0, 8'd4);
      // higher-priority edge during REQ does not change the vector
      add(1'b0, 4'h2, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'hF8, 4'h0, 8'd4);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'hF8, 4'h0, 8'd4);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'hFA, 4'h0, 8'd4);
      add(1'b0, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'hFA, 4'h0, 8'd4);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'hFA, 4'h0, 8'd4);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'hFA, 4'h0, 8'd4);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'hFA, 4'h2, 8'd5);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 8'hFA, 4'h0, 8'd5);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'hF8, 4'h0, 8'd5);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'hF8, 4'h1, 8'd6);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 8'hF8, 4'h0, 8'd6);
      // masking the granted source in REQ keeps the request; edge coincident
      // with ack keeps pending set, so source 2 is requested again
      add(1'b0, 4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'hF8, 4'h0, 8'd6);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'hF8, 4'h0, 8'd6);
      add(1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 8'hFC, 4'h0, 8'd6);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'hFC, 4'h0, 8'd6);
      add(1'b0, 4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'hFC, 4'h0, 8'd6);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'hFC, 4'h4, 8'd7);
      add(1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 8'hFC, 4'h0, 8'd7);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'hFC, 4'h0, 8'd7);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'hFC, 4'h4, 8'd8);
      add(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 8'hFC, 4'h0, 8'd8);

      foreach (tbl[k]) step(tbl[k], "tbl", k);

      // Reset mid-SERVICE with source 1 held high through release.
      drv(1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 8'hFC, 4'h0, 8'd8, "rst_svc", 0);
      drv(1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 8'hFC, 4'h0, 8'd8, "rst_svc", 1);
      drv(1'b0, 4'h2, 1'b0, 1'b0, 1'b1, 8'hFA, 4'h0, 8'd8, "rst_svc", 2);
      drv(1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 8'hFA, 4'h2, 8'd9, "rst_svc", 3);
      drv(1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'd0, "rst_svc", 4);
      drv(1'b1, 4'h2, 1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 8'd0, "rst_svc", 5);
      drv(1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'd0, "rst_svc", 6);
      drv(1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'd0, "rst_svc", 7);
      drv(1'b0, 4'h2, 1'b0, 1'b0, 1'b1, 8'hFA, 4'h0, 8'd0, "rst_svc", 8);
      drv(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'hFA, 4'h2, 8'd1, "rst_svc", 9);
      drv(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 8'hFA, 4'h0, 8'd1, "rst_svc", 10);

      // 260 ack/done rounds on source 0; counter must stop at FF.
      cnt = 8'd1;
      for (int r = 0; r < 260; r++) begin
         logic [7:0] v0;
         v0 = (r == 0) ? 8'hFA : 8'hF8;
         drv(1'b0, 4'h1, 1'b0, 1'b0, 1'b0, v0, 4'h0, cnt, "sat", 5*r);
         drv(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, v0, 4'h0, cnt, "sat", 5*r+1);
         drv(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'hF8, 4'h0, cnt, "sat", 5*r+2);
         if (cnt != 8'hFF) cnt = cnt + 8'd1;
         drv(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'hF8, 4'h1, cnt, "sat", 5*r+3);
         drv(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 8'hF8, 4'h0, cnt, "sat", 5*r+4);
      end
      // stray done in IDLE changes nothing
      drv(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 8'hF8, 4'h0, 8'hFF, "stray_done", 0);
      drv(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'hF8, 4'h0, 8'hFF, "stray_done", 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
